// File: rtl/y86_cc_pc_unit_if.sv
// Execute-stage bus between the instruction datapath and the CC/PC/status unit.
// The master drives the per-instruction fields; the slave returns architectural state.
interface y86_cc_pc_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic             step_en;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [2:0]       cc_i;
    logic [63:0]      valC;
    logic [63:0]      valP;
    logic [63:0]      valM;
    logic             instr_valid;
    logic             imem_error;
    logic             dmem_error;
    logic [63:0]      pc;
    logic [2:0]       cc_q;
    logic             cnd;
    logic [2:0]       stat;
    logic             running;
    logic [CNT_W-1:0] retired;

    modport master (
        output step_en, icode, ifun, cc_i, valC, valP, valM, instr_valid, imem_error, dmem_error,
        input  pc, cc_q, cnd, stat, running, retired
    );

    modport slave (
        input  step_en, icode, ifun, cc_i, valC, valP, valM, instr_valid, imem_error, dmem_error,
        output pc, cc_q, cnd, stat, running, retired
    );
endinterface

// File: rtl/y86_cc_pc_unit.sv
// Y86-64 condition-code register, Cnd evaluation, next-PC register and processor status FSM.
// Commits happen only on step_en edges while running; HALT and FAULT are left only by reset.
module y86_cc_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input logic             clk,
    input logic             rst_n,
    y86_cc_pc_unit_if.slave bus
);
    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StHalt  = 2'd1;
    localparam logic [1:0] StFault = 2'd2;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    localparam logic [3:0] IHalt  = 4'h0;
    localparam logic [3:0] ICmov  = 4'h2;
    localparam logic [3:0] IOpq   = 4'h6;
    localparam logic [3:0] IJxx   = 4'h7;
    localparam logic [3:0] ICall  = 4'h8;
    localparam logic [3:0] IRet   = 4'h9;

    logic [1:0]       state_q, state_d;
    logic [2:0]       stat_q, stat_d;
    logic [63:0]      pc_q, pc_d;
    logic [2:0]       cc_q, cc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             cnd;
    logic             cnd_raw;
    logic             zf, sf, of;

    // Conditions use the registered flags, so cmov/jXX see the previous OPq result.
    always_comb begin
        zf = cc_q[2];
        sf = cc_q[1];
        of = cc_q[0];
        case (bus.ifun)
            4'h0:    cnd_raw = 1'b1;
            4'h1:    cnd_raw = (sf ^ of) | zf;
            4'h2:    cnd_raw = sf ^ of;
            4'h3:    cnd_raw = zf;
            4'h4:    cnd_raw = ~zf;
            4'h5:    cnd_raw = ~(sf ^ of);
            4'h6:    cnd_raw = ~(sf ^ of) & ~zf;
            default: cnd_raw = 1'b0;
        endcase
        cnd = ((bus.icode == ICmov) || (bus.icode == IJxx)) ? cnd_raw : 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        pc_d      = pc_q;
        cc_d      = cc_q;
        retired_d = retired_q;
        if (bus.step_en && (state_q == StRun)) begin
            if (bus.imem_error) begin
                stat_d  = StatAdr;
                state_d = StFault;
            end else if (!bus.instr_valid) begin
                stat_d  = StatIns;
                state_d = StFault;
            end else if (bus.dmem_error) begin
                stat_d  = StatAdr;
                state_d = StFault;
            end else if (bus.icode == IHalt) begin
                stat_d  = StatHlt;
                state_d = StHalt;
            end else begin
                if (bus.icode == IOpq) begin
                    cc_d = bus.cc_i;
                end
                case (bus.icode)
                    ICall:   pc_d = bus.valC;
                    IJxx:    pc_d = cnd ? bus.valC : bus.valP;
                    IRet:    pc_d = bus.valM;
                    default: pc_d = bus.valP;
                endcase
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            stat_q    <= StatAok;
            pc_q      <= RESET_PC;
            cc_q      <= 3'b100;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            pc_q      <= pc_d;
            cc_q      <= cc_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.cc_q    = cc_q;
    assign bus.cnd     = cnd;
    assign bus.stat    = stat_q;
    assign bus.running = (state_q == StRun);
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_y86_cc_pc_unit.sv
// Directed bench for y86_cc_pc_unit: flags, Cnd table, next-PC select, status FSM, saturation.
module tb_y86_cc_pc_unit;
    localparam int unsigned CW  = 4;
    localparam logic [63:0] RPC = 64'h1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nvec = 0;
    int nerr = 0;
    logic [CW-1:0] exp_ret;

    always #5 clk = ~clk;

    y86_cc_pc_unit_if #(.CNT_W(CW)) bus_if ();

    y86_cc_pc_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cc,
                         input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm);
        bus_if.icode = ic;
        bus_if.ifun  = fn;
        bus_if.cc_i  = cc;
        bus_if.valC  = vc;
        bus_if.valP  = vp;
        bus_if.valM  = vm;
    endtask

    task automatic commit(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cc,
                          input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm);
        drive(ic, fn, cc, vc, vp, vm);
        bus_if.step_en = 1'b1;
        @(posedge clk);
        #1;
        bus_if.step_en = 1'b0;
    endtask

    task automatic clear_errors();
        bus_if.instr_valid = 1'b1;
        bus_if.imem_error  = 1'b0;
        bus_if.dmem_error  = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_reset();
        bus_if.step_en     = 1'b1;
        bus_if.imem_error  = 1'b1;
        bus_if.instr_valid = 1'b1;
        bus_if.dmem_error  = 1'b0;
        drive(4'h6, 4'h0, 3'b011, 64'h11, 64'h22, 64'h33);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        bus_if.step_en = 1'b0;
        exp_ret        = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            nvec++;
            if ({bus_if.pc, bus_if.cc_q, bus_if.stat, bus_if.running, bus_if.retired} !==
                {RPC, 3'b100, 3'd1, 1'b1, CW'(0)}) begin
                nerr++;
                $display("FAIL reset_idle[%0d]: got pc=%h cc=%b stat=%0d run=%b ret=%0d", i,
                         bus_if.pc, bus_if.cc_q, bus_if.stat, bus_if.running, bus_if.retired);
            end
        end
        clear_errors();
    endtask

    task automatic test_opq_jl();
        commit(4'h6, 4'h0, 3'b010, 64'h77, 64'h0A, 64'h55);
        exp_ret++;
        nvec++;
        if ({bus_if.cc_q, bus_if.pc, bus_if.retired} !== {3'b010, 64'h0A, exp_ret}) begin
            nerr++;
            $display("FAIL opq: got cc=%b pc=%h ret=%0d want cc=010 pc=0a ret=%0d",
                     bus_if.cc_q, bus_if.pc, bus_if.retired, exp_ret);
        end
        drive(4'h7, 4'h2, 3'b101, 64'h40, 64'h13, 64'h0);
        #1;
        nvec++;
        if (bus_if.cnd !== 1'b1) begin
            nerr++;
            $display("FAIL jl_cnd: got %b want 1", bus_if.cnd);
        end
        commit(4'h7, 4'h2, 3'b101, 64'h40, 64'h13, 64'h0);
        exp_ret++;
        nvec++;
        if ({bus_if.pc, bus_if.retired, bus_if.cc_q} !== {64'h40, exp_ret, 3'b010}) begin
            nerr++;
            $display("FAIL jl_taken: got pc=%h ret=%0d cc=%b want pc=40 ret=%0d cc=010",
                     bus_if.pc, bus_if.retired, bus_if.cc_q, exp_ret);
        end
    endtask

    // Each row: flags loaded by OPq, then expected Cnd for ifun 0..7 (bit i = ifun i).
    task automatic test_cond_table();
        logic [2:0] ccs [3];
        logic [7:0] masks [3];
        logic [7:0] m;
        logic exp_c;
        ccs[0] = 3'b110; masks[0] = 8'b0000_1111;
        ccs[1] = 3'b001; masks[1] = 8'b0001_0111;
        ccs[2] = 3'b000; masks[2] = 8'b0111_0001;
        for (int k = 0; k < 3; k++) begin
            commit(4'h6, 4'h0, ccs[k], 64'h0, 64'h30 + 64'(k), 64'h0);
            exp_ret++;
            m = masks[k];
            for (int f = 0; f < 16; f++) begin
                for (int t = 0; t < 2; t++) begin
                    drive((t == 0) ? 4'h2 : 4'h7, 4'(f), ~ccs[k], 64'h0, 64'h0, 64'h0);
                    #1;
                    exp_c = (f < 8) ? m[f] : 1'b0;
                    nvec++;
                    if (bus_if.cnd !== exp_c) begin
                        nerr++;
                        $display("FAIL cnd_table cc=%b icode=%0d ifun=%0d: got %b want %b",
                                 ccs[k], (t == 0) ? 2 : 7, f, bus_if.cnd, exp_c);
                    end
                end
            end
        end
        drive(4'h3, 4'h0, 3'b000, 64'h0, 64'h0, 64'h0);
        #1;
        nvec++;
        if (bus_if.cnd !== 1'b0) begin
            nerr++;
            $display("FAIL cnd_other_icode: got %b want 0", bus_if.cnd);
        end
    endtask

    task automatic test_cmov_isolation();
        drive(4'h2, 4'h3, 3'b100, 64'h0, 64'h2A, 64'h0);
        #1;
        nvec++;
        if (bus_if.cnd !== 1'b0) begin
            nerr++;
            $display("FAIL cmove_uses_cc_q: got %b want 0", bus_if.cnd);
        end
        commit(4'h2, 4'h3, 3'b100, 64'h0, 64'h2A, 64'h0);
        exp_ret++;
        nvec++;
        if ({bus_if.pc, bus_if.cc_q} !== {64'h2A, 3'b000}) begin
            nerr++;
            $display("FAIL cmove_commit: got pc=%h cc=%b want pc=2a cc=000",
                     bus_if.pc, bus_if.cc_q);
        end
        commit(4'h7, 4'h2, 3'b010, 64'h40, 64'h60, 64'h0);
        exp_ret++;
        nvec++;
        if (bus_if.pc !== 64'h60) begin
            nerr++;
            $display("FAIL jl_not_taken: got pc=%h want 60", bus_if.pc);
        end
    endtask

    task automatic test_ret_call();
        commit(4'h9, 4'h0, 3'b111, 64'h999, 64'h888, 64'h1234);
        exp_ret++;
        nvec++;
        if ({bus_if.pc, bus_if.cc_q} !== {64'h1234, 3'b000}) begin
            nerr++;
            $display("FAIL ret: got pc=%h cc=%b want pc=1234 cc=000", bus_if.pc, bus_if.cc_q);
        end
        commit(4'h8, 4'h0, 3'b111, 64'h200, 64'h70, 64'h5);
        exp_ret++;
        nvec++;
        if ({bus_if.pc, bus_if.cc_q, bus_if.retired} !== {64'h200, 3'b000, exp_ret}) begin
            nerr++;
            $display("FAIL call: got pc=%h cc=%b ret=%0d want pc=200 cc=000 ret=%0d",
                     bus_if.pc, bus_if.cc_q, bus_if.retired, exp_ret);
        end
    endtask

    task automatic test_step_hold();
        drive(4'h6, 4'h0, 3'b111, 64'h1, 64'h2, 64'h3);
        bus_if.imem_error  = 1'b1;
        bus_if.instr_valid = 1'b0;
        bus_if.dmem_error  = 1'b1;
        bus_if.step_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({bus_if.pc, bus_if.cc_q, bus_if.stat, bus_if.retired} !==
            {64'h200, 3'b000, 3'd1, exp_ret}) begin
            nerr++;
            $display("FAIL step_en_low_hold: got pc=%h cc=%b stat=%0d ret=%0d",
                     bus_if.pc, bus_if.cc_q, bus_if.stat, bus_if.retired);
        end
        clear_errors();
    endtask

    task automatic test_halt();
        commit(4'h1, 4'h0, 3'b000, 64'h0, 64'h50, 64'h0);
        exp_ret++;
        commit(4'h0, 4'h0, 3'b010, 64'h7, 64'h8, 64'h9);
        nvec++;
        if ({bus_if.stat, bus_if.running, bus_if.pc, bus_if.retired} !==
            {3'd2, 1'b0, 64'h50, exp_ret}) begin
            nerr++;
            $display("FAIL halt: got stat=%0d run=%b pc=%h ret=%0d want 2 0 50 %0d",
                     bus_if.stat, bus_if.running, bus_if.pc, bus_if.retired, exp_ret);
        end
        commit(4'h6, 4'h0, 3'b001, 64'h0, 64'h99, 64'h0);
        nvec++;
        if ({bus_if.pc, bus_if.cc_q, bus_if.retired, bus_if.stat} !==
            {64'h50, 3'b000, exp_ret, 3'd2}) begin
            nerr++;
            $display("FAIL halt_frozen: got pc=%h cc=%b ret=%0d stat=%0d",
                     bus_if.pc, bus_if.cc_q, bus_if.retired, bus_if.stat);
        end
    endtask

    task automatic test_fault();
        logic [2:0] exp_stat [4];
        exp_stat[0] = 3'd3;
        exp_stat[1] = 3'd4;
        exp_stat[2] = 3'd3;
        exp_stat[3] = 3'd4;
        for (int k = 0; k < 4; k++) begin
            pulse_reset();
            bus_if.imem_error  = (k == 0);
            bus_if.instr_valid = !((k == 0) || (k == 1) || (k == 3));
            bus_if.dmem_error  = (k == 2) || (k == 3);
            commit(4'h6, 4'h0, 3'b011, 64'h0, 64'h77, 64'h0);
            clear_errors();
            nvec++;
            if ({bus_if.stat, bus_if.running, bus_if.pc, bus_if.cc_q, bus_if.retired} !==
                {exp_stat[k], 1'b0, RPC, 3'b100, CW'(0)}) begin
                nerr++;
                $display("FAIL fault[%0d]: got stat=%0d run=%b pc=%h cc=%b ret=%0d want stat=%0d",
                         k, bus_if.stat, bus_if.running, bus_if.pc, bus_if.cc_q,
                         bus_if.retired, exp_stat[k]);
            end
        end
        commit(4'h1, 4'h0, 3'b000, 64'h0, 64'h88, 64'h0);
        nvec++;
        if ({bus_if.pc, bus_if.retired} !== {RPC, CW'(0)}) begin
            nerr++;
            $display("FAIL fault_frozen: got pc=%h ret=%0d", bus_if.pc, bus_if.retired);
        end
        pulse_reset();
        #1;
        nvec++;
        if ({bus_if.pc, bus_if.cc_q, bus_if.stat, bus_if.running, bus_if.retired} !==
            {RPC, 3'b100, 3'd1, 1'b1, CW'(0)}) begin
            nerr++;
            $display("FAIL reset_after_fault: got pc=%h cc=%b stat=%0d run=%b ret=%0d",
                     bus_if.pc, bus_if.cc_q, bus_if.stat, bus_if.running, bus_if.retired);
        end
    endtask

    task automatic test_reset_override();
        commit(4'h6, 4'h0, 3'b001, 64'h0, 64'h44, 64'h0);
        @(negedge clk);
        drive(4'h6, 4'h0, 3'b010, 64'h0, 64'h66, 64'h0);
        bus_if.step_en = 1'b1;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if ({bus_if.pc, bus_if.cc_q, bus_if.retired} !== {RPC, 3'b100, CW'(0)}) begin
            nerr++;
            $display("FAIL reset_override: got pc=%h cc=%b ret=%0d",
                     bus_if.pc, bus_if.cc_q, bus_if.retired);
        end
        bus_if.step_en = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_back_to_back_saturate();
        for (int i = 0; i < 18; i++) begin
            commit(4'h1, 4'h0, 3'b000, 64'h0, 64'h500 + 64'(i), 64'h0);
            if (exp_ret != {CW{1'b1}}) exp_ret++;
            nvec++;
            if ({bus_if.pc, bus_if.retired} !== {64'h500 + 64'(i), exp_ret}) begin
                nerr++;
                $display("FAIL saturate[%0d]: got pc=%h ret=%0d want pc=%h ret=%0d", i,
                         bus_if.pc, bus_if.retired, 64'h500 + 64'(i), exp_ret);
            end
        end
    endtask

    initial begin
        bus_if.step_en = 1'b0;
        clear_errors();
        drive(4'h0, 4'h0, 3'b000, 64'h0, 64'h0, 64'h0);
        test_reset();
        test_opq_jl();
        test_cond_table();
        test_cmov_isolation();
        test_ret_call();
        test_step_hold();
        test_halt();
        test_fault();
        test_reset_override();
        test_back_to_back_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/y86_cc_pc_unit.md
Name: y86_cc_pc_unit

Overview:
- Consumer end of the execute-stage ALU flag interface in the Y86-64 sequential core.
- Holds the architectural condition-code register (ZF, SF, OF), captured from the ALU flag bus on OPq.
- Evaluates the branch/move condition Cnd for jXX and cmovXX, selects and registers the next PC, and runs the processor status state machine (AOK/HLT/ADR/INS) that gates instruction retirement.

Parameters:
- RESET_PC, 64'h0, PC value loaded at reset.
- CNT_W, 32, width of the saturating retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- step_en  in  1  one instruction completes this cycle; state commits only when high
- icode  in  4  instruction code of the current instruction
- ifun  in  4  function code of the current instruction
- cc_i  in  3  ALU flag bus: [2]=ZF, [1]=SF, [0]=OF
- valC  in  64  constant word (jump/call target)
- valP  in  64  fall-through PC
- valM  in  64  memory read value (ret target)
- instr_valid  in  1  fetch decoded a legal icode/ifun
- imem_error  in  1  fetch address fault
- dmem_error  in  1  data memory address fault
- pc  out  64  registered current PC
- cc_q  out  3  registered condition codes, same bit order as cc_i
- cnd  out  1  condition result (combinational from cc_q, icode, ifun)
- stat  out  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- running  out  1  high in state RUN
- retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC, cc_q=3'b100 (ZF=1, SF=0, OF=0), stat=AOK, state=RUN, running=1, retired=0.
  - Reset asserted mid-operation overrides any commit in that cycle.
- States:
  - RUN: commits are accepted.
  - HALT, FAULT: terminal. No further commits; pc, cc_q and retired are frozen. Only reset exits either state.
- cnd:
  - Computed from registered cc_q, never from cc_i. A cmov/jXX therefore sees flags from the most recent prior OPq, not the current ALU output.
  - Evaluated for icode 2 and 7; forced 0 for every other icode.
  - ifun 0: 1. ifun 1 (le): (SF^OF)|ZF. ifun 2 (l): SF^OF. ifun 3 (e): ZF. ifun 4 (ne): ~ZF. ifun 5 (ge): ~(SF^OF). ifun 6 (g): ~(SF^OF)&~ZF. ifun 7-F: 0.
- Commit on rising edge with step_en=1 in RUN. Evaluate in this priority order; the first matching case wins:
  1. imem_error -> stat=ADR, FAULT.
  2. !instr_valid -> stat=INS, FAULT.
  3. dmem_error -> stat=ADR, FAULT.
  4. icode==0 (halt) -> stat=HLT, HALT.
  5. Otherwise normal commit.
- Cases 1-4 leave pc and cc_q unchanged and do not increment retired.
- Normal commit:
  - If icode==6, cc_q<=cc_i; otherwise cc_q holds.
  - pc <= valC for call (8) or for jXX (7) with cnd=1; valM for ret (9); valP in all other cases.
  - retired increments by 1 and saturates at all-ones (no wrap).
- step_en=0: all registers hold, regardless of other inputs, including error inputs.
- cc_i, valC, valP and valM are ignored outside the cycles that use them.
- No latency beyond one cycle: updated pc and cc_q are visible the cycle after the commit edge.

Test Plan:
- Reset release, no step_en for 5 cycles -> pc=RESET_PC, cc_q=3'b100, stat=1, running=1, retired=0 throughout.
- OPq (icode 6) with cc_i=3'b010, valP=0x0A, then jl (icode 7, ifun 2) with valC=0x40, valP=0x13 -> after the first edge cc_q=3'b010, pc=0x0A; cnd=1; after the second edge pc=0x40, retired=2.
- cmove (icode 2, ifun 3) in the same cycle as cc_q=3'b000 and cc_i=3'b100 -> cnd=0, because cc_i is not used for cnd.
- ret (icode 9) with valM=0x1234 -> pc=0x1234; then call (icode 8) with valC=0x200 -> pc=0x200; cc_q unchanged on both.
- halt (icode 0) at pc=0x50 -> stat=2, running=0; later step_en with OPq cc_i=3'b001 and valP=0x99 -> pc stays 0x50, cc_q unchanged, retired unchanged.
- Fault priority: imem_error=1 together with instr_valid=0 -> stat=3. Separately, instr_valid=0 alone -> stat=4. Then assert rst_n=0 for one cycle -> all outputs return to reset values.
